// File: rtl/alu_issue_stage.sv
// Purpose : decode/issue register between RV32I register read and the 32-bit ALU.
// Latency : 1 cycle from accept (in_valid & in_ready) to out_valid.
// Backpr. : outputs hold while out_valid & !out_ready; in_ready = !out_valid | out_ready.
//
// Ports: clk/rst_n (async active-low); in_valid/in_ready/instr/rs1_data/rs2_data on the
// input side; flush kills held and incoming work; out_valid/out_ready/SrcA/SrcB/Operation/
// rd/reg_write/illegal on the output side; alu_result returns the issued op's result.
// Optional feature: define ALU_FWD_EN to forward alu_result into register operands.
module alu_issue_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              instr,
    input  logic [DATA_WIDTH-1:0]    rs1_data,
    input  logic [DATA_WIDTH-1:0]    rs2_data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [4:0]               rd,
    output logic                     reg_write,
    output logic                     illegal,
    input  logic [DATA_WIDTH-1:0]    alu_result
);
    localparam logic [OPCODE_LENGTH-1:0] OP_AND  = 4'b0000;
    localparam logic [OPCODE_LENGTH-1:0] OP_OR   = 4'b0001;
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD  = 4'b0010;
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB  = 4'b0011;
    localparam logic [OPCODE_LENGTH-1:0] OP_SLL  = 4'b0100;
    localparam logic [OPCODE_LENGTH-1:0] OP_SLT  = 4'b0101;
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR  = 4'b0110;
    localparam logic [OPCODE_LENGTH-1:0] OP_SRL  = 4'b0111;
    localparam logic [OPCODE_LENGTH-1:0] OP_SRA  = 4'b1000;
    localparam logic [OPCODE_LENGTH-1:0] OP_BEQ  = 4'b1010;
    localparam logic [OPCODE_LENGTH-1:0] OP_BNE  = 4'b1011;
    localparam logic [OPCODE_LENGTH-1:0] OP_SLTU = 4'b1100;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    logic                     out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]    src_a_q, src_a_d;
    logic [DATA_WIDTH-1:0]    src_b_q, src_b_d;
    logic [OPCODE_LENGTH-1:0] op_q, op_d;
    logic [4:0]               rd_q, rd_d;
    logic                     reg_write_q, reg_write_d;
    logic                     illegal_q, illegal_d;

    logic                     accept;
    logic [DATA_WIDTH-1:0]    rs1_op, rs2_op;
    logic [DATA_WIDTH-1:0]    dec_a, dec_b;
    logic [OPCODE_LENGTH-1:0] dec_op;
    logic [4:0]               dec_rd;
    logic                     dec_rw, dec_ill;

    logic [6:0]               opcode, funct7;
    logic [2:0]               funct3;
    logic [DATA_WIDTH-1:0]    imm_i, imm_s, shamt;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
    assign imm_s  = {{(DATA_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign shamt  = {{(DATA_WIDTH-5){1'b0}}, instr[24:20]};

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

`ifdef ALU_FWD_EN
    // The op currently on the outputs is the one the ALU is evaluating, so its
    // result is newer than the register file for a dependent follower.
    logic fwd_rs1, fwd_rs2;
    assign fwd_rs1 = out_valid_q && reg_write_q && (rd_q != 5'd0) && (rd_q == instr[19:15]);
    assign fwd_rs2 = out_valid_q && reg_write_q && (rd_q != 5'd0) && (rd_q == instr[24:20]);
    assign rs1_op  = fwd_rs1 ? alu_result : rs1_data;
    assign rs2_op  = fwd_rs2 ? alu_result : rs2_data;
`else
    assign rs1_op = rs1_data;
    assign rs2_op = rs2_data;
    logic unused_alu_result;
    assign unused_alu_result = ^alu_result;
`endif

    always_comb begin
        dec_a   = rs1_op;
        dec_b   = rs2_op;
        dec_op  = OP_ADD;
        dec_rd  = instr[11:7];
        dec_rw  = 1'b0;
        dec_ill = 1'b0;
        case (opcode)
            OPC_R: begin
                dec_rw = 1'b1;
                if (funct7 == F7_ZERO) begin
                    case (funct3)
                        3'b000:  dec_op = OP_ADD;
                        3'b001:  dec_op = OP_SLL;
                        3'b010:  dec_op = OP_SLT;
                        3'b011:  dec_op = OP_SLTU;
                        3'b100:  dec_op = OP_XOR;
                        3'b101:  dec_op = OP_SRL;
                        3'b110:  dec_op = OP_OR;
                        default: dec_op = OP_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_op = OP_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_op = OP_SRA;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            OPC_I: begin
                dec_rw = 1'b1;
                dec_b  = imm_i;
                case (funct3)
                    3'b000: dec_op = OP_ADD;
                    3'b010: dec_op = OP_SLT;
                    3'b011: dec_op = OP_SLTU;
                    3'b100: dec_op = OP_XOR;
                    3'b110: dec_op = OP_OR;
                    3'b111: dec_op = OP_AND;
                    3'b001: begin
                        dec_b   = shamt;
                        dec_op  = OP_SLL;
                        dec_ill = (funct7 != F7_ZERO);
                    end
                    default: begin
                        dec_b   = shamt;
                        dec_op  = instr[30] ? OP_SRA : OP_SRL;
                        dec_ill = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
                    end
                endcase
            end
            OPC_LOAD: begin
                dec_b  = imm_i;
                dec_rw = 1'b1;
            end
            OPC_STORE: begin
                dec_b  = imm_s;
                dec_rd = 5'd0;
            end
            OPC_BRANCH: begin
                dec_rd = 5'd0;
                case (funct3)
                    3'b000:  dec_op = OP_BEQ;
                    3'b001:  dec_op = OP_BNE;
                    3'b100:  dec_op = OP_SLT;
                    3'b110:  dec_op = OP_SLTU;
                    default: dec_ill = 1'b1;   // BGE/BGEU have no single ALU op here
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
        if (dec_ill) begin
            dec_op = OP_AND;
            dec_rw = 1'b0;
        end
        // x0 is never written, whatever the instruction says.
        if (dec_rd == 5'd0) begin
            dec_rw = 1'b0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        src_a_d     = src_a_q;
        src_b_d     = src_b_q;
        op_d        = op_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        illegal_d   = illegal_q;
        if (flush) begin
            // Only the valid bit is cleared; payload regs keep stale contents.
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            src_a_d     = dec_a;
            src_b_d     = dec_b;
            op_d        = dec_op;
            rd_d        = dec_rd;
            reg_write_d = dec_rw;
            illegal_d   = dec_ill;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            src_a_q     <= '0;
            src_b_q     <= '0;
            op_q        <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            src_a_q     <= src_a_d;
            src_b_q     <= src_b_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign SrcA      = src_a_q;
    assign SrcB      = src_b_q;
    assign Operation = op_q;
    assign rd        = rd_q;
    assign reg_write = reg_write_q;
    assign illegal   = illegal_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Purpose : self-checking bench for alu_issue_stage, scoreboard of expected issue packets.
// Latency : expects each accepted instruction on the outputs one cycle after accept.
// Backpr. : drives out_ready low in places to exercise holding and in_ready deassertion.
module tb_alu_issue_stage;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [3:0]  Operation;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;
    logic [31:0] alu_result;

    alu_issue_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .Operation  (Operation),
        .rd         (rd),
        .reg_write  (reg_write),
        .illegal    (illegal),
        .alu_result (alu_result)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard side: every output beat taken by EX must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_issue", {28'd0, Operation}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("operation", {28'd0, Operation}, {28'd0, e.op});
                check_eq("reg_write", {31'd0, reg_write}, {31'd0, e.rw});
                check_eq("illegal",   {31'd0, illegal},   {31'd0, e.ill});
                if (!e.ill) begin
                    check_eq("srca", SrcA, e.a);
                    check_eq("srcb", SrcB, e.b);
                    check_eq("rd",   {27'd0, rd}, {27'd0, e.rd});
                end
            end
        end
    end

    // Present one instruction until accepted; expectation is queued on the accepting edge.
    task automatic send(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd_e, input logic rw, input logic ill);
        exp_t e;
        logic acc;
        int   cyc;
        e.op = op; e.a = a; e.b = b; e.rd = rd_e; e.rw = rw; e.ill = ill;
        in_valid = 1'b1;
        instr    = ins;
        rs1_data = r1;
        rs2_data = r2;
        acc      = 1'b0;
        cyc      = 0;
        while (!acc && cyc < 50) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) sb.push_back(e);
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!acc) check_eq("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    logic [31:0] exp_fwd_a;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        instr      = 32'h0;
        rs1_data   = 32'h0;
        rs2_data   = 32'h0;
        flush      = 1'b0;
        out_ready  = 1'b1;
        alu_result = 32'hDEAD_BEEF;
        #12;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_srca",      SrcA, 32'd0);
        check_eq("rst_operation", {28'd0, Operation}, 32'd0);
        check_eq("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Decode table, back-to-back issue at full throughput.
        send(32'h002081B3, 32'd5, 32'hFFFF_FFF9, 4'b0010, 32'd5, 32'hFFFF_FFF9, 5'd3, 1'b1, 1'b0); // ADD x3,x1,x2
        send(32'h40435293, 32'h8000_0000, 32'd1, 4'b1000, 32'h8000_0000, 32'd4, 5'd5, 1'b1, 1'b0); // SRAI x5,x6,4
        send(32'h40431293, 32'd1, 32'd1, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);                // SLLI, bit30 set
        send(32'h40208233, 32'd10, 32'd3, 4'b0011, 32'd10, 32'd3, 5'd4, 1'b1, 1'b0);              // SUB x4,x1,x2
        send(32'hFFF08393, 32'd9, 32'd1, 4'b0010, 32'd9, 32'hFFFF_FFFF, 5'd7, 1'b1, 1'b0);        // ADDI x7,x1,-1
        send(32'h00513413, 32'd2, 32'd1, 4'b1100, 32'd2, 32'd5, 5'd8, 1'b1, 1'b0);                // SLTIU x8,x2,5
        send(32'h00812483, 32'h100, 32'd1, 4'b0010, 32'h100, 32'd8, 5'd9, 1'b1, 1'b0);            // LW x9,8(x2)
        send(32'hFE512E23, 32'h200, 32'd7, 4'b0010, 32'h200, 32'hFFFF_FFFC, 5'd0, 1'b0, 1'b0);    // SW x5,-4(x2)
        send(32'h00209063, 32'd11, 32'd12, 4'b1011, 32'd11, 32'd12, 5'd0, 1'b0, 1'b0);            // BNE x1,x2
        send(32'h0020E063, 32'd13, 32'd14, 4'b1100, 32'd13, 32'd14, 5'd0, 1'b0, 1'b0);            // BLTU x1,x2
        send(32'h0020D063, 32'd1, 32'd2, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);                // BGE -> illegal
        send(32'h4020F1B3, 32'd1, 32'd2, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);                // AND, bad funct7
        send(32'h00208033, 32'd3, 32'd4, 4'b0010, 32'd3, 32'd4, 5'd0, 1'b0, 1'b0);                // ADD x0 -> no write
        send(32'h000012B7, 32'd1, 32'd2, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);                // LUI -> illegal
        send(32'h407352B3, 32'hF000_0000, 32'd3, 4'b1000, 32'hF000_0000, 32'd3, 5'd5, 1'b1, 1'b0); // SRA x5,x6,x7
        send(32'h0020A1B3, 32'd21, 32'd22, 4'b0101, 32'd21, 32'd22, 5'd3, 1'b1, 1'b0);            // SLT x3,x1,x2
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: held packet frozen, in_ready low, next issued once released.
        out_ready = 1'b0;
        send(32'h40208233, 32'd40, 32'd2, 4'b0011, 32'd40, 32'd2, 5'd4, 1'b1, 1'b0);              // SUB x4,x1,x2
        in_valid = 1'b1;
        instr    = 32'hFFF08393;
        rs1_data = 32'd77;
        rs2_data = 32'd0;
        repeat (3) begin
            @(negedge clk);
            check_eq("bp_in_ready",  {31'd0, in_ready}, 32'd0);
            check_eq("bp_srca_hold", SrcA, 32'd40);
            check_eq("bp_op_hold",   {28'd0, Operation}, 32'd3);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_release_rdy", {31'd0, in_ready}, 32'd1);
        sb.push_back('{op: 4'b0010, a: 32'd77, b: 32'hFFFF_FFFF, rd: 5'd7, rw: 1'b1, ill: 1'b0});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("bp_next_issued", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;

        // Flush with a held packet and a same-cycle accept: the incoming one never appears.
        out_ready = 1'b0;
        send(32'h002081B3, 32'd1, 32'd2, 4'b0010, 32'd1, 32'd2, 5'd3, 1'b1, 1'b0);
        in_valid  = 1'b1;
        instr     = 32'h00513413;
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("flush_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check_eq("flush_stays_empty", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;

        // Forwarding from the op currently on the outputs.
`ifdef ALU_FWD_EN
        exp_fwd_a = 32'h10;
`else
        exp_fwd_a = 32'h0;
`endif
        alu_result = 32'h10;
        send(32'h002080B3, 32'd1, 32'd2, 4'b0010, 32'd1, 32'd2, 5'd1, 1'b1, 1'b0);                // ADD x1,x1,x2
        send(32'h40208233, 32'd0, 32'd3, 4'b0011, exp_fwd_a, 32'd3, 5'd4, 1'b1, 1'b0);           // SUB x4,x1,x2
        send(32'h002083B3, 32'd5, 32'd6, 4'b0010, 32'd5, 32'd6, 5'd7, 1'b1, 1'b0);                // ADD x7,x1,x2
        send(32'h00708313, 32'd100, 32'd0, 4'b0010, 32'd100, 32'd7, 5'd6, 1'b1, 1'b0);            // ADDI x6,x1,7
        alu_result = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        check_eq("sb_drained", sb.size(), 32'd0);

        // Asynchronous reset while a packet is held.
        out_ready = 1'b0;
        send(32'h002081B3, 32'd9, 32'd8, 4'b0010, 32'd9, 32'd8, 5'd3, 1'b1, 1'b0);
        check_eq("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("arst_srca",      SrcA, 32'd0);
        check_eq("arst_srcb",      SrcB, 32'd0);
        check_eq("arst_operation", {28'd0, Operation}, 32'd0);
        check_eq("arst_rd",        {27'd0, rd}, 32'd0);
        check_eq("arst_reg_write", {31'd0, reg_write}, 32'd0);
        check_eq("arst_illegal",   {31'd0, illegal}, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
